// File: rtl/can_bit_timing.sv
// CAN receive front end: pin synchroniser, tq-based bit timing with hard sync on SOF,
// sample-point capture, bus integration and bit destuffing.
module can_bit_timing #(
  parameter int IDLE_BITS = 11,
  parameter int STUFF_LEN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       can_in,
  input  logic [7:0] brp,
  input  logic [3:0] tseg1,
  input  logic [2:0] tseg2,
  input  logic       stuff_en,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       stuff_err,
  output logic       bus_idle
);

  localparam int REC_W = $clog2(IDLE_BITS + 1);
  localparam logic [REC_W-1:0] REC_MAX = REC_W'(IDLE_BITS);
  localparam logic [2:0] STUFF_RUN = 3'(STUFF_LEN);

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  logic             sync1_q, sync2_q, rx_prev_q;
  logic [7:0]       cnt_q, cnt_d;
  logic [4:0]       q_q, q_d;
  logic [7:0]       brp_q;
  logic [3:0]       tseg1_q;
  logic [2:0]       tseg2_q;
  state_t           state_q, state_d;
  logic [REC_W-1:0] rec_q, rec_d;
  logic [2:0]       run_q, run_d;
  logic             last_q, last_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             stuff_err_q, stuff_err_d;
  logic             bus_idle_q, bus_idle_d;

  logic             rx_s, fall_s, hard_sync_s, tq_tick_s, sample_s;
  logic [7:0]       brp_s, cnt_s;
  logic [3:0]       tseg1_s;
  logic [2:0]       tseg2_s;
  logic [4:0]       q_s, q_last_s, q_sp_s;
  logic [REC_W-1:0] rec_next_s;

  // A hard sync acts in the very cycle of the edge, so the live config and a
  // zeroed position replace the registered ones for that cycle.
  assign rx_s        = sync2_q;
  assign fall_s      = ~rx_s & rx_prev_q;
  assign hard_sync_s = fall_s & (state_q != ST_RUN);
  assign brp_s       = hard_sync_s ? brp   : brp_q;
  assign tseg1_s     = hard_sync_s ? tseg1 : tseg1_q;
  assign tseg2_s     = hard_sync_s ? tseg2 : tseg2_q;
  assign cnt_s       = hard_sync_s ? 8'd0  : cnt_q;
  assign q_s         = hard_sync_s ? 5'd0  : q_q;
  assign q_last_s    = {1'b0, tseg1_s} + {2'b00, tseg2_s} + 5'd2;
  assign q_sp_s      = {1'b0, tseg1_s} + 5'd1;
  assign tq_tick_s   = (cnt_s == brp_s);
  assign sample_s    = tq_tick_s & (q_s == q_sp_s);
  assign rec_next_s  = rx_s ? ((rec_q == REC_MAX) ? rec_q : rec_q + {{(REC_W-1){1'b0}}, 1'b1})
                            : {REC_W{1'b0}};

  // Time-quantum counter and quantum index
  always_comb begin
    cnt_d = cnt_s;
    q_d   = q_s;
    if (tq_tick_s) begin
      cnt_d = 8'd0;
      if (q_s == q_last_s) begin
        q_d = 5'd0;
      end else begin
        q_d = q_s + 5'd1;
      end
    end else begin
      cnt_d = cnt_s + 8'd1;
    end
  end

  // Integration / idle / run state machine with destuffing
  always_comb begin
    state_d     = state_q;
    rec_d       = rec_q;
    run_d       = run_q;
    last_d      = last_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    stuff_err_d = 1'b0;
    case (state_q)
      ST_INTEGRATE: begin
        if (sample_s) begin
          rec_d = rec_next_s;
          if (rec_next_s == REC_MAX) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_INTEGRATE;
          end
        end else begin
          state_d = ST_INTEGRATE;
        end
      end
      ST_IDLE: begin
        if (fall_s) begin
          state_d = ST_RUN;
          run_d   = 3'd0;
          last_d  = 1'b1;
          rec_d   = {REC_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (sample_s) begin
          rec_d = rec_next_s;
          if (stuff_en && (run_q == STUFF_RUN)) begin
            if (rx_s != last_q) begin
              run_d   = 3'd1;
              last_d  = rx_s;
              state_d = (rec_next_s == REC_MAX) ? ST_IDLE : ST_RUN;
            end else begin
              stuff_err_d = 1'b1;
              rec_d       = {REC_W{1'b0}};
              state_d     = ST_INTEGRATE;
            end
          end else begin
            bit_out_d   = rx_s;
            bit_valid_d = 1'b1;
            if (rx_s == last_q) begin
              run_d = (run_q == 3'd7) ? 3'd7 : run_q + 3'd1;
            end else begin
              run_d = 3'd1;
            end
            last_d  = rx_s;
            state_d = (rec_next_s == REC_MAX) ? ST_IDLE : ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INTEGRATE;
        rec_d   = {REC_W{1'b0}};
      end
    endcase
    bus_idle_d = (state_d == ST_IDLE);
  end

  // Synchroniser, timing, captured config, FSM and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      cnt_q       <= 8'd0;
      q_q         <= 5'd0;
      brp_q       <= brp;
      tseg1_q     <= tseg1;
      tseg2_q     <= tseg2;
      state_q     <= ST_INTEGRATE;
      rec_q       <= {REC_W{1'b0}};
      run_q       <= 3'd0;
      last_q      <= 1'b1;
      bit_out_q   <= 1'b1;
      bit_valid_q <= 1'b0;
      stuff_err_q <= 1'b0;
      bus_idle_q  <= 1'b0;
    end else begin
      sync1_q     <= can_in;
      sync2_q     <= sync1_q;
      rx_prev_q   <= sync2_q;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      brp_q       <= brp_s;
      tseg1_q     <= tseg1_s;
      tseg2_q     <= tseg2_s;
      state_q     <= state_d;
      rec_q       <= rec_d;
      run_q       <= run_d;
      last_q      <= last_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      stuff_err_q <= stuff_err_d;
      bus_idle_q  <= bus_idle_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign stuff_err = stuff_err_q;
  assign bus_idle  = bus_idle_q;

endmodule

// File: tb/tb_can_bit_timing.sv
// Bench for can_bit_timing: a bit-position model checked every cycle, directed
// scenarios with hand-computed cycle expectations, then randomized frames.
module tb_can_bit_timing;
  localparam int IDLE_BITS = 11;
  localparam int STUFF_LEN = 5;
  localparam int LOGN = 512;

  logic       clk = 1'b0;
  logic       reset, can_in, stuff_en;
  logic [7:0] brp;
  logic [3:0] tseg1;
  logic [2:0] tseg2;
  logic       bit_out, bit_valid, stuff_err, bus_idle;

  can_bit_timing #(.IDLE_BITS(IDLE_BITS), .STUFF_LEN(STUFF_LEN)) dut (
    .clk(clk), .reset(reset), .can_in(can_in), .brp(brp), .tseg1(tseg1),
    .tseg2(tseg2), .stuff_en(stuff_en), .bit_out(bit_out), .bit_valid(bit_valid),
    .stuff_err(stuff_err), .bus_idle(bus_idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ref_cyc = -100000;
  bit chk_en = 1'b0;
  bit lg_v[LOGN], lg_o[LOGN], lg_e[LOGN], lg_i[LOGN];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: position within the bit since the last hard sync, plus the
  // integration / run rules applied at each sample point.
  typedef enum int {M_INT, M_IDLE, M_RUN} mstate_t;
  mstate_t m_state;
  bit  m_s1, m_s2, m_prev, m_last;
  int  m_t, m_brp, m_ts1, m_ts2, m_rec, m_run;
  bit  e_out, e_valid, e_err, e_idle;

  always @(posedge clk) begin : model
    bit rx, fall, smp;
    int bitlen, rn;
    cyc++;
    if (reset) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b1; m_t = 0;
      m_brp = int'(brp); m_ts1 = int'(tseg1); m_ts2 = int'(tseg2);
      m_state = M_INT; m_rec = 0; m_run = 0; m_last = 1'b1;
      e_out = 1'b1; e_valid = 1'b0; e_err = 1'b0; e_idle = 1'b0;
    end else begin
      rx = m_s2;
      fall = !rx && m_prev;
      e_valid = 1'b0;
      e_err = 1'b0;
      rn = 0;
      if (fall && m_state != M_RUN) begin
        m_t = 0; m_brp = int'(brp); m_ts1 = int'(tseg1); m_ts2 = int'(tseg2);
      end
      bitlen = (m_ts1 + m_ts2 + 3) * (m_brp + 1);
      smp = (m_t == (m_ts1 + 2) * (m_brp + 1) - 1);
      m_t = (m_t + 1) % bitlen;
      if (smp) rn = rx ? ((m_rec < IDLE_BITS) ? m_rec + 1 : m_rec) : 0;
      case (m_state)
        M_INT: if (smp) begin
          m_rec = rn;
          if (m_rec == IDLE_BITS) m_state = M_IDLE;
        end
        M_IDLE: if (fall) begin
          m_state = M_RUN; m_run = 0; m_last = 1'b1; m_rec = 0;
        end
        default: if (smp) begin
          if (stuff_en && m_run == STUFF_LEN && rx == m_last) begin
            e_err = 1'b1; m_rec = 0; m_state = M_INT;
          end else begin
            if (stuff_en && m_run == STUFF_LEN) begin
              m_run = 1;
            end else begin
              e_valid = 1'b1; e_out = rx;
              m_run = (rx == m_last) ? ((m_run < 7) ? m_run + 1 : 7) : 1;
            end
            m_last = rx;
            m_rec = rn;
            if (m_rec == IDLE_BITS) m_state = M_IDLE;
          end
        end
      endcase
      e_idle = (m_state == M_IDLE);
      m_prev = m_s2; m_s2 = m_s1; m_s1 = can_in;
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("bit_valid", int'(bit_valid), int'(e_valid));
      check("bit_out", int'(bit_out), int'(e_out));
      check("stuff_err", int'(stuff_err), int'(e_err));
      check("bus_idle", int'(bus_idle), int'(e_idle));
    end
  end

  task automatic tick();
    int rel;
    @(negedge clk);
    rel = cyc - ref_cyc;
    if (rel >= 0 && rel < LOGN) begin
      lg_v[rel] = bit_valid; lg_o[rel] = bit_out; lg_e[rel] = stuff_err; lg_i[rel] = bus_idle;
    end
  endtask

  task automatic start_log(input int offset);
    for (int i = 0; i < LOGN; i++) begin
      lg_v[i] = 1'b0; lg_o[i] = 1'b0; lg_e[i] = 1'b0; lg_i[i] = 1'b0;
    end
    ref_cyc = cyc + offset;
  endtask

  task automatic send_bit(input bit b, input int n, input int glitch_at);
    for (int k = 0; k < n; k++) begin
      can_in = (k == glitch_at) ? ~b : b;
      tick();
    end
    can_in = b;
  endtask

  function automatic int count_v(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(lg_v[i]);
    return c;
  endfunction

  function automatic int count_e(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(lg_e[i]);
    return c;
  endfunction

  initial begin : stim
    bit fr1 [9];
    int strobe_c [8];
    int nb, bl, g;
    bit b, prev;
    fr1 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    strobe_c = '{10, 26, 42, 58, 74, 90, 106, 138};
    reset = 1'b1; can_in = 1'b1; brp = 8'd1; tseg1 = 4'd3; tseg2 = 3'd2; stuff_en = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("reset_bit_out", int'(bit_out), 1);
    check("reset_bit_valid", int'(bit_valid), 0);
    check("reset_bus_idle", int'(bus_idle), 0);

    // Integration: 11 recessive bit times reach IDLE
    repeat (12 * 16) tick();
    check("integrated_idle", int'(bus_idle), 1);

    // Frame with one stuff bit, 16 clocks per bit
    start_log(2);
    for (int i = 0; i < 9; i++) send_bit(fr1[i], 16, -1);
    stuff_en = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(1'b1, 16, -1);
    check("sof_idle_cycle0", int'(lg_i[0]), 1);
    check("sof_idle_cycle1", int'(lg_i[1]), 0);
    check("first_strobe_c9", int'(lg_v[9]), 0);
    for (int i = 0; i < 8; i++) begin
      check("frame_strobe", int'(lg_v[strobe_c[i]]), 1);
      check("frame_bit", int'(lg_o[strobe_c[i]]), 0 + ((i == 1) ? 1 : 0));
    end
    check("stuff_slot_122", int'(lg_v[122]), 0);
    check("frame_strobe_count", count_v(0, 141), 8);
    check("frame_back_idle", int'(bus_idle), 1);

    // Six dominant bits with destuffing on: stuff error on the sixth
    stuff_en = 1'b1;
    start_log(2);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 16, -1);
    for (int i = 0; i < 13; i++) send_bit(1'b1, 16, -1);
    check("err_strobe_count", count_v(0, 89), 5);
    check("err_pulse_89", int'(lg_e[89]), 0);
    check("err_pulse_90", int'(lg_e[90]), 1);
    check("err_pulse_91", int'(lg_e[91]), 0);
    check("err_no_valid_90", int'(lg_v[90]), 0);
    check("err_pulse_count", count_e(0, 302), 1);
    check("err_idle_265", int'(lg_i[265]), 0);
    check("err_idle_266", int'(lg_i[266]), 1);

    // Same pattern with destuffing off: six strobes, no error
    stuff_en = 1'b0;
    start_log(2);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 16, -1);
    for (int i = 0; i < 12; i++) send_bit(1'b1, 16, -1);
    for (int i = 0; i < 6; i++) begin
      check("nostuff_strobe", int'(lg_v[10 + 16 * i]), 1);
      check("nostuff_bit", int'(lg_o[10 + 16 * i]), 0);
    end
    check("nostuff_err_count", count_e(0, 286), 0);
    check("nostuff_idle", int'(bus_idle), 1);

    // Minimum timing: 3 clocks per bit, config captured at the hard sync
    brp = 8'd0; tseg1 = 4'd0; tseg2 = 3'd0; stuff_en = 1'b1;
    start_log(2);
    for (int i = 0; i < 7; i++) send_bit(1'(i % 2), 3, -1);
    stuff_en = 1'b0;
    for (int i = 0; i < 13; i++) send_bit(1'b1, 3, -1);
    check("fast_c1", int'(lg_v[1]), 0);
    check("fast_c2", int'(lg_v[2]), 1);
    check("fast_c2_bit", int'(lg_o[2]), 0);
    check("fast_c3", int'(lg_v[3]), 0);
    check("fast_c4", int'(lg_v[4]), 0);
    check("fast_c5", int'(lg_v[5]), 1);
    check("fast_c5_bit", int'(lg_o[5]), 1);
    check("fast_c8", int'(lg_v[8]), 1);
    check("fast_idle", int'(bus_idle), 1);

    // Reset mid-bit in RUN, then a dominant glitch during integration
    brp = 8'd1; tseg1 = 4'd3; tseg2 = 3'd2; stuff_en = 1'b1;
    start_log(2);
    send_bit(1'b0, 16, -1);
    check("pre_reset_bit_out", int'(bit_out), 0);
    send_bit(1'b1, 4, -1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_bit_out", int'(bit_out), 1);
    check("midreset_valid", int'(bit_valid), 0);
    check("midreset_err", int'(stuff_err), 0);
    check("midreset_idle", int'(bus_idle), 0);
    start_log(0);
    send_bit(1'b1, 6 * 16, -1);
    send_bit(1'b0, 16, -1);
    send_bit(1'b1, 20 * 16, -1);
    check("glitch_restart_idle", int'(lg_i[185]), 0);
    check("glitch_final_idle", int'(bus_idle), 1);

    // Randomized frames against the model
    for (int f = 0; f < 16; f++) begin
      brp = 8'($urandom_range(0, 2));
      tseg1 = 4'($urandom_range(0, 5));
      tseg2 = 3'($urandom_range(0, 2));
      stuff_en = 1'b1;
      bl = (int'(tseg1) + int'(tseg2) + 3) * (int'(brp) + 1);
      nb = int'($urandom_range(8, 30));
      prev = 1'b0;
      start_log(2);
      for (int i = 0; i < nb; i++) begin
        if (i == 0) b = 1'b0;
        else if ($urandom_range(0, 3) == 0) b = prev;
        else b = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) stuff_en = 1'b0;
        g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, bl - 1)) : -1;
        send_bit(b, bl, g);
        prev = b;
      end
      stuff_en = 1'b0;
      for (int i = 0; i < 13; i++) send_bit(1'b1, bl, -1);
      check("random_frame_idle", int'(bus_idle), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
